// File: rtl/data_mem_be.sv
// Byte-enabled data memory for the MIPS MEM stage: sub-word stores with lane merge,
// sign/zero-extended sub-word loads on a registered read port, and a zero-clear sweep.
module data_mem_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter bit TRACE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        busy
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [31:0]     ram [DEPTH];

  logic [AW-1:0]   widx;
  logic [1:0]      boff;
  logic            err;
  logic            accept;
  logic            do_store;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [31:0]     old_word;
  logic [31:0]     merged;
  logic [31:0]     shifted;
  logic [31:0]     load_ext;

  assign widx     = addr[AW+1:2];
  assign boff     = addr[1:0];
  assign old_word = ram[widx];
  // ready is registered and mirrors state==S_RUN, so it doubles as the accept qualifier.
  assign accept   = ready && req && !clr;
  assign do_store = accept && we && !err;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    err      = 1'b0;
    be       = 4'b0000;
    wlanes   = wdata;
    load_ext = old_word;
    shifted  = old_word >> {boff, 3'b000};
    case (size)
      2'b00: begin
        be       = 4'b0001 << boff;
        wlanes   = {4{wdata[7:0]}};
        load_ext = sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      end
      2'b01: begin
        err      = boff[0];
        be       = boff[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata[15:0]}};
        load_ext = sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      end
      2'b10: begin
        err = (boff != 2'b00);
        be  = 4'b1111;
      end
      default: err = 1'b1;
    endcase
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = be[k] ? wlanes[8*k +: 8] : old_word[8*k +: 8];
  end

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_CLEAR;
      clr_idx  <= '0;
      ready    <= 1'b0;
      busy     <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      addr_err <= 1'b0;
    end else begin
      rvalid   <= accept && (!we || err);
      addr_err <= accept && err;
      if (accept && err)
        rdata <= '0;
      else if (accept && !we)
        rdata <= load_ext;

      case (state)
        S_CLEAR: begin
          if (clr) begin
            clr_idx <= '0;
          end else if (clr_idx == AW'(DEPTH - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        S_RUN: begin
          if (clr) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      ram[clr_idx] <= '0;
    end else if (do_store) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) ram[widx][8*k +: 8] <= wlanes[8*k +: 8];
    end
  end

`ifndef SYNTHESIS
  if (TRACE) begin : g_trace
    always_ff @(posedge clk) begin
      if (reset && do_store)
        $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[31:AW+2], pc};

endmodule

// File: tb/tb_data_mem_be.sv
// Randomised scoreboard bench for data_mem_be: byte-array reference model,
// decoupled response monitor, and clear-sweep / reset timing checks.
module tb_data_mem_be;

  localparam int DEPTH = 1024;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset, clr, req, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        ready, rvalid, addr_err, busy;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_mem_be #(.DEPTH(DEPTH), .TRACE(1'b1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .req(req), .we(we), .size(size),
    .sign(sign), .addr(addr), .wdata(wdata), .pc(pc), .ready(ready),
    .rvalid(rvalid), .rdata(rdata), .addr_err(addr_err), .busy(busy)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [7:0] mem_m [NB];
  rsp_t       exp_q [$];
  rsp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Reference model: memory is a flat little-endian byte array indexed by byte address mod NB.
  function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int base = int'(a & (NB - 1));
    for (int k = 0; k < nbytes(s); k++) mem_m[base + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
    int          base = int'(a & (NB - 1));
    int          n    = nbytes(s);
    logic [31:0] v    = '0;
    for (int k = 0; k < n; k++) v |= 32'(mem_m[base + k]) << (8 * k);
    if (sg && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected rvalid: got data %h err %b, want no response", rdata, addr_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp addr_err", 32'(addr_err), 32'(mon_e.err));
        check("rsp rdata", rdata, mon_e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request at posedge+1; it is accepted at the next posedge.
  task automatic issue(input logic w, input logic [1:0] s, input logic sg, input logic [31:0] a,
                       input logic [31:0] d, input bit use_exp, input logic [31:0] exp_v);
    check("ready at issue", 32'(ready), 32'd1);
    req = 1'b1; we = w; size = s; sign = sg; addr = a; wdata = d; pc = $urandom;
    if (is_err(s, a))
      exp_q.push_back('{err: 1'b1, data: 32'd0});
    else if (w)
      model_store(s, a, d);
    else
      exp_q.push_back('{err: 1'b0, data: use_exp ? exp_v : model_load(s, sg, a)});
    tick(1);
    req = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    int bad = 0;
    while (ready !== 1'b1 && n < 5000) begin
      if (busy !== 1'b1) bad++;
      tick(1);
      n++;
    end
    check({name, " sweep cycles"}, 32'(n), 32'd1024);
    check({name, " busy low in sweep"}, 32'(bad), 32'd0);
    check({name, " busy after sweep"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " ready"}, 32'(ready), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd1);
    check({name, " rvalid"}, 32'(rvalid), 32'd0);
    check({name, " rdata"}, rdata, 32'd0);
    check({name, " addr_err"}, 32'(addr_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic        w, sg;
    logic [1:0]  s;
    logic [31:0] a;

    reset = 1'b0; clr = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10;
    sign = 1'b0; addr = '0; wdata = '0; pc = '0;
    model_clear();
    tick(3);
    check_reset_values("reset");
    reset = 1'b1;
    wait_sweep("power-up");

    issue(1'b0, 2'b10, 1'b0, {$urandom_range(0, 255), 2'b00}, '0, 1'b1, 32'd0);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, '0);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b1, 32'h1122_AA44);
    issue(1'b0, 2'b00, 1'b1, 32'h11, '0, 1'b1, 32'hFFFF_FFAA);
    issue(1'b0, 2'b00, 1'b0, 32'h11, '0, 1'b1, 32'h0000_00AA);
    issue(1'b0, 2'b01, 1'b1, 32'h12, '0, 1'b1, 32'h0000_1122);
    issue(1'b0, 2'b01, 1'b0, 32'h10, '0, 1'b1, 32'h0000_AA44);
    issue(1'b0, 2'b10, 1'b0, 32'h12, '0, 1'b0, '0);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_BEEF, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b1, 32'h1122_AA44);
    issue(1'b0, 2'b10, 1'b0, 32'h1010, '0, 1'b1, 32'h1122_AA44);
    issue(1'b0, 2'b11, 1'b0, 32'h14, '0, 1'b0, '0);
    tick(3);

    // clr with a same-cycle store: the store must be dropped.
    clr = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    tick(1);
    clr = 1'b0; req = 1'b0;
    model_clear();
    check("clr ready drop", 32'(ready), 32'd0);
    check("clr busy rise", 32'(busy), 32'd1);
    wait_sweep("clr");
    issue(1'b0, 2'b10, 1'b0, 32'h10, '0, 1'b1, 32'd0);

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, '0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b1, 32'hCAFE_F00D);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(499);
    reset = 1'b0;
    #1;
    check_reset_values("mid-sweep reset");
    tick(2);
    reset = 1'b1;
    model_clear();
    wait_sweep("mid-sweep reset");
    issue(1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b1, 32'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) tick(1);
      w  = 1'($urandom_range(1));
      s  = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2));
      sg = 1'($urandom_range(1));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if ($urandom_range(3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      issue(w, s, sg, a, $urandom, 1'b0, '0);
    end
    tick(4);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
